// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO and valid/ready input; frame shape fixed at elaboration.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits (PARITY_ODD selects odd/even).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 870,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  state_t                 state_reg, state_next;
  logic [CW-1:0]          clk_cnt_reg, clk_cnt_next;
  logic [IW-1:0]          bit_idx_reg, bit_idx_next, bit_idx_inc;
  logic                   tx_reg, tx_next;
  logic [AW:0]            count_reg, count_next;
  logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [DATA_BITS-1:0]   shift_reg, data_shifted;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic                   push, pop, bit_done;

  assign in_ready     = (count_reg != FULL);
  assign push         = in_valid && in_ready;
  assign bit_done     = (clk_cnt_reg == LAST_CLK);
  assign bit_idx_inc  = bit_idx_reg + 1'b1;
  assign data_shifted = shift_reg >> bit_idx_inc;

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
  assign parity_bit = (^shift_reg) ^ (PARITY_ODD != 0);
`endif

  // Storage has no reset so it maps onto block RAM; the popped word lands in shift_reg.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
    if (pop)  shift_reg <= mem[rd_ptr_reg];
  end

  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = clk_cnt_reg;
    bit_idx_next = bit_idx_reg;
    tx_next      = tx_reg;
    pop          = 1'b0;
    if (state_reg != ST_IDLE) clk_cnt_next = bit_done ? '0 : clk_cnt_reg + 1'b1;
    case (state_reg)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = ST_START;
          tx_next    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_next   = ST_DATA;
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_idx_reg == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
            state_next   = ST_PARITY;
            tx_next      = parity_bit;
`else
            state_next   = ST_STOP;
            tx_next      = 1'b1;
            bit_idx_next = '0;
`endif
          end else begin
            bit_idx_next = bit_idx_inc;
            tx_next      = data_shifted[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          state_next   = ST_STOP;
          tx_next      = 1'b1;
          bit_idx_next = '0;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          if (bit_idx_reg == LAST_STOP) begin
            // Chain straight into the next start bit when more bytes are queued.
            if (count_reg != '0) begin
              pop        = 1'b1;
              state_next = ST_START;
              tx_next    = 1'b0;
            end else begin
              state_next = ST_IDLE;
              tx_next    = 1'b1;
            end
          end else begin
            bit_idx_next = bit_idx_inc;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      clk_cnt_reg <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
      count_reg   <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
      count_reg   <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  assign tx         = tx_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: records the tx line per cycle and decodes it
// against the bytes the bench handed over.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int SB    = 1;
  localparam int DEPTH = 16;
  localparam int PODD  = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif
  localparam int NB    = 1 + DB + PEN + SB;
  localparam int FRAME = NB * CPB;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;

  int n_assert;
  int n_fail;

  logic       tx_tr[$];
  logic       busy_tr[$];
  logic       rdy_tr[$];
  logic [4:0] cnt_tr[$];
  logic [7:0] exp_q[$];
  int         starts[$];

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    tx_tr.push_back(tx);
    busy_tr.push_back(busy);
    rdy_tr.push_back(in_ready);
    cnt_tr.push_back(fifo_count);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic begin_trace();
    tx_tr.delete();
    busy_tr.delete();
    rdy_tr.delete();
    cnt_tr.delete();
    sample();
  endtask

  // Line level for bit slot j of a frame carrying byte d.
  function automatic logic frame_bit(input logic [7:0] d, input int j);
    logic [7:0] t;
    if (j == 0) return 1'b0;
    if (j <= DB) begin
      t = d >> (j - 1);
      return t[0];
    end
    if (PEN == 1 && j == DB + 1) return (^d) ^ (PODD != 0);
    return 1'b1;
  endfunction

  // Walk the recorded line, match every frame to the next expected byte.
  task automatic check_trace(input string tag);
    int i;
    int errs;
    int decoded;
    int nexp;
    logic [7:0] e;
    i = 0;
    decoded = 0;
    nexp = exp_q.size();
    starts.delete();
    while (i < tx_tr.size()) begin
      if (tx_tr[i] === 1'b1) begin
        i++;
      end else begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        errs = 0;
        for (int k = 0; k < FRAME; k++)
          if (i + k >= tx_tr.size() || tx_tr[i+k] !== frame_bit(e, k / CPB)) errs++;
        chk($sformatf("%s frame %0d byte %02h", tag, decoded, e), 32'(errs), 32'd0);
        starts.push_back(i);
        decoded++;
        i += FRAME;
      end
    end
    chk({tag, " frame count"}, 32'(decoded), 32'(nexp));
  endtask

  initial begin
    int errs;
    int n;
    int last_acc;
    int w;
    int gap;
    logic exp_bit;
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state and idle line
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset fifo_count", 32'(fifo_count), 32'd0);
    reset = 1'b0;
    begin_trace();
    steps(50);
    errs = 0;
    foreach (tx_tr[c]) if (tx_tr[c] !== 1'b1) errs++;
    chk("idle tx high", 32'(errs), 32'd0);

    // Single byte 0xA5 written at cycle 0
    begin_trace();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    in_valid = 1'b0;
    steps(FRAME + 10);
    errs = 0;
    foreach (tx_tr[c]) begin
      exp_bit = (c >= 2 && c < 2 + FRAME) ? frame_bit(8'hA5, (c - 2) / CPB) : 1'b1;
      if (tx_tr[c] !== exp_bit) errs++;
    end
    chk("A5 waveform", 32'(errs), 32'd0);
    chk("A5 busy before start", 32'(busy_tr[1]), 32'd0);
    chk("A5 busy at start", 32'(busy_tr[2]), 32'd1);
    chk("A5 busy last stop", 32'(busy_tr[1+FRAME]), 32'd1);
    chk("A5 busy after frame", 32'(busy_tr[2+FRAME]), 32'd0);

    // Held in_valid with 0x00..0x10: FIFO fills, back-to-back frames
    begin_trace();
    n = 0;
    last_acc = -1;
    for (int c = 0; c < 2 + 17 * FRAME + 10; c++) begin
      in_valid = (n < 17);
      in_data  = 8'(n);
      if (in_valid && in_ready) begin
        exp_q.push_back(8'(n));
        last_acc = c;
        n++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("burst accepted", 32'(n), 32'd17);
    chk("burst last accept cycle", 32'(last_acc), 32'd16);
    chk("burst full ready", 32'(rdy_tr[17]), 32'd0);
    chk("burst full count", 32'(cnt_tr[17]), 32'(DEPTH));
    chk("burst ready before first pop", 32'(rdy_tr[1+FRAME]), 32'd0);
    chk("burst ready after first pop", 32'(rdy_tr[2+FRAME]), 32'd1);
    check_trace("burst");
    chk("burst first start", 32'(starts[0]), 32'd2);
    errs = 0;
    for (int k = 0; k + 1 < starts.size(); k++)
      if (starts[k+1] - starts[k] != FRAME) errs++;
    chk("burst frame spacing", 32'(errs), 32'd0);

    // Two bytes queued together: no gap between frames
    begin_trace();
    in_valid = 1'b1;
    in_data  = 8'h55;
    exp_q.push_back(8'h55);
    step();
    in_data  = 8'h0F;
    exp_q.push_back(8'h0F);
    step();
    in_valid = 1'b0;
    steps(2 * FRAME + 10);
    check_trace("pair");
    chk("pair first start", 32'(starts[0]), 32'd2);
    chk("pair second start", 32'(starts[1]), 32'(2 + FRAME));
    chk("pair busy end", 32'(busy_tr[1+2*FRAME]), 32'd1);
    chk("pair idle after", 32'(busy_tr[2+2*FRAME]), 32'd0);

    // Reset mid-frame
    begin_trace();
    in_valid = 1'b1;
    in_data  = 8'h00;
    step();
    in_data  = 8'h81;
    step();
    in_data  = 8'h3C;
    step();
    in_valid = 1'b0;
    steps(7);
    chk("midreset line low", 32'(tx_tr[10]), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset tx", 32'(tx), 32'd1);
    chk("midreset fifo_count", 32'(fifo_count), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset in_ready", 32'(in_ready), 32'd1);
    steps(3 * FRAME);
    errs = 0;
    for (int c = 11; c < tx_tr.size(); c++) if (tx_tr[c] !== 1'b1) errs++;
    chk("midreset no further frame", 32'(errs), 32'd0);

    // Random bytes with random producer gaps, including one long pause
    begin_trace();
    for (int b = 0; b < 40; b++) begin
      gap = (b == 20) ? 200 : int'($urandom_range(0, 3));
      in_valid = 1'b0;
      steps(gap);
      in_valid = 1'b1;
      in_data  = (b == 0) ? 8'h01 : 8'($urandom_range(0, 255));
      w = 0;
      while (!in_ready && w < 3000) begin
        step();
        w++;
      end
      chk($sformatf("random ready byte %0d", b), 32'(in_ready), 32'd1);
      exp_q.push_back(in_data);
      step();
      in_valid = 1'b0;
    end
    w = 0;
    while ((busy || fifo_count != 0) && w < 5000) begin
      step();
      w++;
    end
    chk("random drained", {26'd0, busy, fifo_count}, 32'd0);
    steps(3);
    check_trace("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
